// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor.
// Operands are captured on start and processed one bit per clock, LSB first,
// through a single full adder. Subtraction is done as a + ~b + ~cin, so the
// stored operand is inverted at capture and the carry flop is seeded with
// cin ^ mode. The result, carry-out and overflow flag are published together
// on entry to DONE and held stable until the next result is published.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             c_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic             s_d;
  logic             c_d;

  // Full adder on the current LSB of both operand shift registers.
  always_comb begin
    s_d = a_q[0] ^ b_q[0] ^ c_q;
    c_d = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
  end

  // Control FSM with datapath shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= mode ? ~b : b;
            c_q     <= cin ^ mode;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          // One bit per edge; inputs on the ports are not looked at here.
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          c_q   <= c_d;
          res_q <= {s_d, res_q[WIDTH-1:1]};
          cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == LAST_BIT) begin
            // c_q is the carry into the MSB, c_d the carry out of it.
            sum_q   <= {s_d, res_q[WIDTH-1:1]};
            cout_q  <= c_d;
            ovf_q   <= c_q ^ c_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= ST_RUN;
          end
        end

        ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Back-to-back: capture immediately, no IDLE cycle.
            a_q     <= a;
            b_q     <= mode ? ~b : b;
            c_q     <= cin ^ mode;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub (WIDTH=8).
module tb_serial_add_sub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks;
  int failures;

  serial_add_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Run one operation; optionally pulse start with junk operands mid-RUN.
  task automatic run_op(input string tag, input logic m, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic [7:0] es, input logic ec, input logic eo,
                        input logic glitch);
    int edges;
    int busy_cnt;
    logic [7:0] prior;
    logic sum_moved;
    @(negedge clk);
    start = 1'b1; mode = m; a = av; b = bv; cin = ci;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; busy_cnt = 0; prior = sum; sum_moved = 1'b0;
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      if (sum !== prior) sum_moved = 1'b1;
      if (glitch && edges == 3) begin
        start = 1'b1; mode = ~m; a = 8'hFF; b = 8'hA5; cin = ~ci;
      end else if (glitch && edges == 4) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    check_val({tag, "_latency"}, 64'(edges), 64'd8);
    check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd8);
    check_val({tag, "_sum_held"}, 64'(sum_moved), 64'd0);
    check_val({tag, "_sum"}, 64'(sum), 64'(es));
    check_val({tag, "_cout"}, 64'(cout), 64'(ec));
    check_val({tag, "_ovf"}, 64'(ovf), 64'(eo));
    check_val({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check_val({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check_val({tag, "_result_stable"}, 64'(sum), 64'(es));
  endtask

  initial begin
    int extra_done;
    int first_done;
    int second_done;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    #12;
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_done", 64'(done), 64'd0);
    check_val("reset_sum", 64'(sum), 64'd0);
    check_val("reset_cout", 64'(cout), 64'd0);
    check_val("reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add_ovf",    1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("add_carry",  1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    run_op("add_ff_ff",  1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("add_plain",  1'b0, 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0);
    run_op("sub_borrow", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf",    1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
    run_op("sub_bin",    1'b1, 8'h10, 8'h00, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);

    // Mid-RUN start pulse with new operands must be ignored.
    run_op("ignore",     1'b0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check_val("ignore_no_extra_done", 64'(extra_done), 64'd0);

    // Reset in the middle of RUN.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h55; b = 8'h22; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    check_val("midrun_busy", 64'(busy), 64'd1);
    #2; rst_n = 1'b0; #1;
    check_val("midrun_rst_busy", 64'(busy), 64'd0);
    check_val("midrun_rst_done", 64'(done), 64'd0);
    check_val("midrun_rst_sum", 64'(sum), 64'd0);
    check_val("midrun_rst_cout", 64'(cout), 64'd0);
    check_val("midrun_rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra_done++;
    end
    check_val("midrun_no_done", 64'(extra_done), 64'd0);
    run_op("after_rst",  1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held through DONE.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; a = 8'h01; b = 8'h02; cin = 1'b0;
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20;
    first_done = -1; second_done = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (first_done >= 0 && e == first_done + 1) begin
        check_val("b2b_no_idle_gap", 64'(busy), 64'd1);
        start = 1'b0;
      end
      if (done) begin
        if (first_done < 0) begin
          first_done = e;
          check_val("b2b_first_sum", 64'(sum), 64'h03);
        end else if (second_done < 0) begin
          second_done = e;
          check_val("b2b_second_sum", 64'(sum), 64'h30);
        end
      end
    end
    start = 1'b0;
    check_val("b2b_first_latency", 64'(first_done), 64'd8);
    check_val("b2b_spacing", 64'(second_done - first_done), 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
